instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Holds the program counter and instruction memory, and presents one instruction per cycle to the decode/control stage. It consumes the branch-taken flags (`beq`, `bneq`, `bge`, `blt`) produced by `data_path`, together with `jump`, to redirect fetch. Taken branches cost one bubble cycle. A small load port fills instruction memory from the testbench or boot logic.

## Interface
- `IMEM_DEPTH`, 64: instruction memory depth in 32-bit words; power of two, ≥4.
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `AW`, $clog2(IMEM_DEPTH): derived word-address width; not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `beq`  in  1  taken flag from `data_path` for the presented instruction.
- `bneq`  in  1  taken flag from `data_path`.
- `bge`  in  1  taken flag from `data_path`.
- `blt`  in  1  taken flag from `data_path`.
- `jump`  in  1  unconditional jump from control.
- `imm_val`  in  32  signed byte offset for the branch/jump target.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `imem_we`  in  1  instruction-memory write enable.
- `imem_waddr`  in  AW  word address for the write.
- `imem_wdata`  in  32  write data.
- `pc`  out  32  byte address of `instr`.
- `instr`  out  32  fetched instruction.
- `instr_valid`  out  1  `instr`/`pc` are valid.
- `flush`  out  1  high during the redirect bubble.
- `fault`  out  1  sticky fetch fault.
- `fetch_count`  out  32  number of accepted instructions.

## Operation
- **States**
  - FILL: after reset.
  - RUN
  - REDIRECT
  - FAULT
- **Memory**
  - Synchronous read, registered into `instr`.
  - Read-first: a write to the address being read on the same edge returns the old word.
  - Contents are not cleared by `rst`.
- **Accept** = `instr_valid & instr_ready`. Branch inputs are sampled only on accept and are ignored otherwise.
- **taken** = `beq | bneq | bge | blt | jump`.
  - target = `pc + imm_val`, mod 2^32.
  - Multiple flags set at once: same target, single redirect.
- **Bad address** (`npc` = next PC)
  - `npc[1:0] != 0`, or `npc[31:2] >= IMEM_DEPTH`.
  - `npc[31:2]` is the full 30-bit index, so no wrap-around occurs.
- **FILL**
  - Read `mem[RESET_PC[AW+1:2]]`.
  - Next edge: load `instr`, go to RUN.
  - If `RESET_PC` is a bad address, go to FAULT instead.
- **RUN, no accept**: `pc` and `instr` hold (stall).
- **RUN, accept, not taken**
  - `npc = pc+4`.
  - If bad, go to FAULT.
  - Else `pc<=npc`, `instr<=mem[npc]`, stay in RUN. Throughput is 1 per cycle.
- **RUN, accept, taken**
  - `npc = target`.
  - If bad, go to FAULT.
  - Else `pc<=target`, go to REDIRECT.
- **REDIRECT**: read `mem[pc]`; next edge load `instr`, go to RUN.
- **FAULT**: `pc` holds the offending address. Stays in FAULT until `rst`.
- **`fetch_count`**: +1 per accept, including the accept that causes a fault; wraps at 2^32.

## Timing
- **Reset values (asynchronous)**
  - `pc`=`RESET_PC`
  - `instr`=32'h0000_0013 (NOP)
  - `instr_valid`=0, `flush`=0, `fault`=0
  - `fetch_count`=0
  - state=FILL
- **Outputs by state**
  - `instr_valid`=1 only in RUN.
  - `flush`=1 only in REDIRECT.
  - `fault`=1 only in FAULT.
- **First valid instruction**: rising edge 1 after reset release.
- **Not-taken accept at edge N**: next instruction valid right after edge N.
- **Taken accept at edge N**
  - Cycle after N: `instr_valid`=0, `flush`=1, `pc`=target.
  - Target instruction valid after edge N+1.
- **Stall**: `pc` and `instr` stable while `instr_valid & !instr_ready`; no handshake combinational loop from `instr_ready` to `instr_valid`.
- **`rst` asserted mid-redirect or mid-stall**: immediate return to reset values. Any pending branch is discarded.
- **Memory write latency**: a write at edge N is visible to a read issued at edge N+1 or later.

## Test plan
- **Load and run**: load mem[0..3]=0xA,0xB,0xC,0xD, release `rst`, `instr_ready`=1 → `instr` 0xA,0xB,0xC,0xD on consecutive cycles; `pc` 0,4,8,12; `fetch_count`=4.
- **Stall**: hold `instr_ready`=0 for 3 cycles at pc=4 → `pc`=4 and `instr`=0xB held, `fetch_count` unchanged; branch flags pulsed during the stall are ignored.
- **Taken branch**: at pc=8, `beq`=1, `imm_val`=−8 → next cycle `flush`=1, `instr_valid`=0, `pc`=0; following cycle `instr`=0xA, valid.
- **Simultaneous flags**: `jump`=1 and `blt`=1 with `imm_val`=12 at pc=0 → single bubble, `pc`=12, `instr`=0xD.
- **Faults**
  - Taken with `imm_val`=2 at pc=0 → FAULT, `pc`=2, `fault`=1, `instr_valid`=0; stays until `rst`.
  - Sequential fetch past `IMEM_DEPTH`−1 (pc=252, `IMEM_DEPTH`=64) → FAULT with `pc`=256.
- **Async reset and read-first**
  - `rst` pulsed mid-REDIRECT → outputs at reset values without a clock edge; restart fetches mem[0].
  - Write mem[1]=0xE on the same edge that reads mem[1] → old 0xB is returned.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// Module   : instruction_fetch_unit_if
// Brief    : Fetch-side bus: branch flags, decode handshake, imem load port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if #(
    parameter int AW = 6
);
    logic          beq;
    logic          bneq;
    logic          bge;
    logic          blt;
    logic          jump;
    logic [31:0]   imm_val;
    logic          instr_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          flush;
    logic          fault;
    logic [31:0]   fetch_count;

    modport master (
        output beq, bneq, bge, blt, jump, imm_val, instr_ready,
               imem_we, imem_waddr, imem_wdata,
        input  pc, instr, instr_valid, flush, fault, fetch_count
    );

    modport slave (
        input  beq, bneq, bge, blt, jump, imm_val, instr_ready,
               imem_we, imem_waddr, imem_wdata,
        output pc, instr, instr_valid, flush, fault, fetch_count
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : PC + instruction memory; one instruction per cycle, 1-cycle
//            bubble on taken branch/jump, sticky fault on bad fetch address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          AW         = $clog2(IMEM_DEPTH)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    instruction_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Full 30-bit word index is compared so out-of-range targets never alias.
    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(IMEM_DEPTH));
    endfunction

    localparam logic RESET_BAD = bad_addr(RESET_PC);

    logic [31:0] mem [IMEM_DEPTH];

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        flush;
    logic        fault;
    logic [31:0] fetch_count;

    logic        accept;
    logic        taken;
    logic [31:0] npc;
    logic        npc_bad;

    assign accept  = instr_valid & bus.instr_ready;
    assign taken   = bus.beq | bus.bneq | bus.bge | bus.blt | bus.jump;
    assign npc     = taken ? (pc + bus.imm_val) : (pc + 32'd4);
    assign npc_bad = bad_addr(npc);

    // Write port; non-blocking update gives read-first behaviour for the
    // fetch register below.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_valid <= 1'b0;
            flush       <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                FILL: begin
                    if (RESET_BAD) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        instr       <= mem[pc[AW+1:2]];
                        instr_valid <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        fetch_count <= fetch_count + 32'd1;
                        pc          <= npc;
                        if (npc_bad) begin
                            state       <= FAULT;
                            instr_valid <= 1'b0;
                            fault       <= 1'b1;
                        end else if (taken) begin
                            state       <= REDIRECT;
                            instr_valid <= 1'b0;
                            flush       <= 1'b1;
                        end else begin
                            instr <= mem[npc[AW+1:2]];
                        end
                    end
                end
                REDIRECT: begin
                    instr       <= mem[pc[AW+1:2]];
                    instr_valid <= 1'b1;
                    flush       <= 1'b0;
                    state       <= RUN;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

    assign bus.pc          = pc;
    assign bus.instr       = instr;
    assign bus.instr_valid = instr_valid;
    assign bus.flush       = flush;
    assign bus.fault       = fault;
    assign bus.fetch_count = fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed bench for instruction_fetch_unit with hand-computed
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    localparam int IMEM_DEPTH = 64;
    localparam int AW         = 6;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    instruction_fetch_unit_if #(.AW(AW)) bus ();

    instruction_fetch_unit #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_flags();
        bus.beq = 1'b0; bus.bneq = 1'b0; bus.bge = 1'b0;
        bus.blt = 1'b0; bus.jump = 1'b0; bus.imm_val = 32'd0;
    endtask

    // Reset over one negedge-to-negedge window, then one edge through FILL.
    task automatic restart();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_pc"},    bus.pc, 32'h0);
        check_val({tag, "_instr"}, bus.instr, 32'h13);
        check_val({tag, "_vld"},   32'(bus.instr_valid), 32'd0);
        check_val({tag, "_flush"}, 32'(bus.flush), 32'd0);
        check_val({tag, "_fault"}, 32'(bus.fault), 32'd0);
        check_val({tag, "_cnt"},   bus.fetch_count, 32'd0);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        clear_flags();
        bus.instr_ready = 1'b0;
        bus.imem_we     = 1'b0;
        bus.imem_waddr  = '0;
        bus.imem_wdata  = 32'd0;
        #1;
        check_reset_vals("rst0");

        // Load mem[0..3] = A..D, rest = 0x100 + index.
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            @(negedge clk);
            bus.imem_we    = 1'b1;
            bus.imem_waddr = AW'(i);
            bus.imem_wdata = (i < 4) ? 32'hA + 32'(i) : 32'h100 + 32'(i);
        end
        @(negedge clk);
        bus.imem_we = 1'b0;

        // Load and run
        bus.instr_ready = 1'b1;
        restart();
        check_val("run_vld0", 32'(bus.instr_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("run_instr%0d", i), bus.instr, 32'hA + 32'(i));
            check_val($sformatf("run_pc%0d", i), bus.pc, 32'(4 * i));
            tick();
        end
        check_val("run_cnt", bus.fetch_count, 32'd4);
        check_val("run_instr4", bus.instr, 32'h104);

        // Stall at pc=4 with flags pulsed
        restart();
        tick();
        bus.instr_ready = 1'b0;
        bus.beq = 1'b1; bus.jump = 1'b1; bus.imm_val = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("stall_pc%0d", i), bus.pc, 32'd4);
            check_val($sformatf("stall_instr%0d", i), bus.instr, 32'hB);
            check_val($sformatf("stall_cnt%0d", i), bus.fetch_count, 32'd1);
        end
        clear_flags();
        bus.instr_ready = 1'b1;
        tick();
        check_val("post_stall_pc", bus.pc, 32'd8);
        check_val("post_stall_instr", bus.instr, 32'hC);

        // Taken branch at pc=8, imm=-8
        bus.beq = 1'b1; bus.imm_val = 32'hFFFF_FFF8;
        tick();
        clear_flags();
        check_val("br_flush", 32'(bus.flush), 32'd1);
        check_val("br_vld", 32'(bus.instr_valid), 32'd0);
        check_val("br_pc", bus.pc, 32'd0);
        check_val("br_cnt", bus.fetch_count, 32'd3);
        tick();
        check_val("br_tgt_instr", bus.instr, 32'hA);
        check_val("br_tgt_vld", 32'(bus.instr_valid), 32'd1);
        check_val("br_tgt_flush", 32'(bus.flush), 32'd0);

        // Simultaneous jump + blt, imm=12
        bus.jump = 1'b1; bus.blt = 1'b1; bus.imm_val = 32'd12;
        tick();
        clear_flags();
        check_val("multi_flush", 32'(bus.flush), 32'd1);
        check_val("multi_pc", bus.pc, 32'd12);
        tick();
        check_val("multi_instr", bus.instr, 32'hD);
        check_val("multi_vld", 32'(bus.instr_valid), 32'd1);
        check_val("multi_flush2", 32'(bus.flush), 32'd0);
        check_val("multi_cnt", bus.fetch_count, 32'd4);

        // Async reset mid-REDIRECT
        bus.bneq = 1'b1; bus.imm_val = 32'hFFFF_FFF4;
        tick();
        clear_flags();
        check_val("redir_flush", 32'(bus.flush), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_val("arst_restart_instr", bus.instr, 32'hA);
        check_val("arst_restart_vld", 32'(bus.instr_valid), 32'd1);

        // Misaligned taken target -> FAULT
        bus.jump = 1'b1; bus.imm_val = 32'd2;
        tick();
        clear_flags();
        check_val("mis_fault", 32'(bus.fault), 32'd1);
        check_val("mis_pc", bus.pc, 32'd2);
        check_val("mis_vld", 32'(bus.instr_valid), 32'd0);
        check_val("mis_flush", 32'(bus.flush), 32'd0);
        repeat (3) tick();
        check_val("mis_sticky", 32'(bus.fault), 32'd1);
        check_val("mis_pc_hold", bus.pc, 32'd2);
        check_val("mis_cnt", bus.fetch_count, 32'd1);

        // Read-first: write mem[1]=E on the edge that reads mem[1]
        restart();
        check_val("rf_fault_clr", 32'(bus.fault), 32'd0);
        bus.imem_we = 1'b1; bus.imem_waddr = AW'(1); bus.imem_wdata = 32'hE;
        tick();
        bus.imem_we = 1'b0;
        check_val("rf_old", bus.instr, 32'hB);
        check_val("rf_pc", bus.pc, 32'd4);
        restart();
        tick();
        check_val("rf_new", bus.instr, 32'hE);

        // Sequential fetch past the last word
        restart();
        for (int i = 0; i < 80 && !bus.fault; i++) begin
            if (bus.pc == 32'd252)
                check_val("end_instr", bus.instr, 32'h13F);
            tick();
        end
        check_val("end_fault", 32'(bus.fault), 32'd1);
        check_val("end_pc", bus.pc, 32'd256);
        check_val("end_cnt", bus.fetch_count, 32'd64);
        check_val("end_vld", 32'(bus.instr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
